// File: rtl/reduce_seq_if.sv
// -----------------------------------------------------------------------------
// reduce_seq_if
//   Request/response bundle for the reduce_seq bit-reduction unit.
//
//   Request side  : in_valid, in_ready, in_data[WIDTH], mode[2]
//   Response side : out_valid, out_ready, out_bit, out_hit, out_idx[IW]
//
//   master : the requester/consumer (drives in_*, mode, out_ready)
//   slave  : the reduction unit     (drives in_ready and out_*)
// -----------------------------------------------------------------------------
interface reduce_seq_if #(
    parameter int WIDTH = 16
);
    localparam int IW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic             out_hit;
    logic [IW-1:0]    out_idx;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_bit, out_hit, out_idx
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_bit, out_hit, out_idx
    );
endinterface

// File: rtl/reduce_seq.sv
// -----------------------------------------------------------------------------
// reduce_seq
//   Multi-cycle bit reduction of a WIDTH-bit word, CHUNK bits per cycle, under
//   a selectable mode (00 OR, 01 AND, 10 XOR, 11 NOR). Also reports whether
//   any bit was set and the index of the lowest set bit.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : reduce_seq_if.slave
//             in_valid/in_ready/in_data/mode  - request handshake
//             out_valid/out_ready             - response handshake
//             out_bit/out_hit/out_idx         - registered results
//
//   Flow: IDLE accepts one word, RUN folds one chunk per edge for N = WIDTH/CHUNK
//   edges, DONE presents the result until the consumer takes it. in_ready is
//   high only in IDLE, so a new word is never taken in the cycle a result leaves.
// -----------------------------------------------------------------------------
module reduce_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    reduce_seq_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_OR  = 2'b00,
        MODE_AND = 2'b01,
        MODE_XOR = 2'b10,
        MODE_NOR = 2'b11
    } mode_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    mode_e            mode_q,  mode_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             acc_q,   acc_d;
    logic             bit_q,   bit_d;
    logic             hit_q,   hit_d;
    logic [IW-1:0]    idx_q,   idx_d;

    // Current chunk and the position of its lowest set bit.
    logic [CHUNK-1:0] chunk;
    logic             chunk_nz;
    int               pos;

    always_comb begin
        chunk    = CHUNK'(data_q >> (int'(cnt_q) * CHUNK));
        chunk_nz = |chunk;
        pos      = 0;
        // Scan from the top down so the lowest set bit is the last one written.
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk[i]) pos = i;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        bit_d   = bit_q;
        hit_d   = hit_q;
        idx_d   = idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    mode_d  = mode_e'(bus.mode);
                    cnt_d   = '0;
                    // AND starts from the identity 1; OR/XOR/NOR start from 0.
                    acc_d   = (mode_e'(bus.mode) == MODE_AND);
                    bit_d   = 1'b0;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                unique case (mode_q)
                    MODE_AND: acc_d = acc_q & (&chunk);
                    MODE_XOR: acc_d = acc_q ^ (^chunk);
                    default:  acc_d = acc_q | chunk_nz;
                endcase

                // Only the first nonzero chunk defines the index.
                if (!hit_q && chunk_nz) begin
                    hit_d = 1'b1;
                    idx_d = IW'(int'(cnt_q) * CHUNK + pos);
                end

                if (cnt_q == CW'(N - 1)) begin
                    bit_d   = acc_d ^ (mode_q == MODE_NOR);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mode_q  <= MODE_OR;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            bit_q   <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            bit_q   <= bit_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

    // All outputs come straight from registers; in_ready depends on state only.
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_bit   = bit_q;
    assign bus.out_hit   = hit_q;
    assign bus.out_idx   = idx_q;

endmodule

// File: tb/tb_reduce_seq.sv
// -----------------------------------------------------------------------------
// tb_reduce_seq
//   Three instances: 16/4 (main), 8/8 (single-cycle), 32/8 (random sweep).
//   Expected values come from a hand-written vector table and from a
//   bit-counting reference model.
// -----------------------------------------------------------------------------
module tb_reduce_seq;
    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    reduce_seq_if #(.WIDTH(16)) if16 ();
    reduce_seq_if #(.WIDTH(8))  if8  ();
    reduce_seq_if #(.WIDTH(32)) if32 ();

    reduce_seq #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    reduce_seq #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    reduce_seq #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] d, input logic [1:0] m);
        case (sel)
            0: begin if16.in_valid = v; if16.in_data = d[15:0]; if16.mode = m; end
            1: begin if8.in_valid  = v; if8.in_data  = d[7:0];  if8.mode  = m; end
            default: begin if32.in_valid = v; if32.in_data = d; if32.mode = m; end
        endcase
    endtask

    task automatic set_out_ready(input int sel, input logic r);
        case (sel)
            0: if16.out_ready = r;
            1: if8.out_ready  = r;
            default: if32.out_ready = r;
        endcase
    endtask

    function automatic int get_valid(input int sel);
        case (sel)
            0: return int'(if16.out_valid);
            1: return int'(if8.out_valid);
            default: return int'(if32.out_valid);
        endcase
    endfunction

    function automatic int get_ready(input int sel);
        case (sel)
            0: return int'(if16.in_ready);
            1: return int'(if8.in_ready);
            default: return int'(if32.in_ready);
        endcase
    endfunction

    function automatic int get_bit(input int sel);
        case (sel)
            0: return int'(if16.out_bit);
            1: return int'(if8.out_bit);
            default: return int'(if32.out_bit);
        endcase
    endfunction

    function automatic int get_hit(input int sel);
        case (sel)
            0: return int'(if16.out_hit);
            1: return int'(if8.out_hit);
            default: return int'(if32.out_hit);
        endcase
    endfunction

    function automatic int get_idx(input int sel);
        case (sel)
            0: return int'(if16.out_idx);
            1: return int'(if8.out_idx);
            default: return int'(if32.out_idx);
        endcase
    endfunction

    // Reference: count the ones, then decide each mode from the count.
    task automatic ref_reduce(input logic [31:0] d, input int w, input logic [1:0] m,
                              output int b, output int h, output int idx);
        int ones;
        ones = 0;
        h    = 0;
        idx  = 0;
        for (int i = 0; i < w; i++) begin
            if (d[i]) begin
                ones++;
                if (h == 0) begin
                    h   = 1;
                    idx = i;
                end
            end
        end
        case (m)
            2'b00:   b = (ones > 0)  ? 1 : 0;
            2'b01:   b = (ones == w) ? 1 : 0;
            2'b10:   b = ones % 2;
            default: b = (ones == 0) ? 1 : 0;
        endcase
    endtask

    // Accept one word and wait for out_valid. lat = edges from accept to valid.
    // proto_bad flags in_ready seen high while busy or low when idle.
    task automatic run_op(input int sel, input logic [31:0] d, input logic [1:0] m,
                          output int b, output int h, output int idx,
                          output int lat, output int proto_bad);
        proto_bad = 0;
        @(negedge clk);
        if (get_ready(sel) != 1) proto_bad = 1;
        drive(sel, 1'b1, d, m);
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge; they must not matter.
        drive(sel, 1'b0, $urandom, 2'($urandom));
        lat = 0;
        while (get_valid(sel) == 0 && lat < 64) begin
            if (get_ready(sel) != 0) proto_bad = 1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (get_ready(sel) != 0) proto_bad = 1;
        b   = get_bit(sel);
        h   = get_hit(sel);
        idx = get_idx(sel);
    endtask

    // With out_ready high, the result leaves on the next edge and in_ready returns.
    task automatic check_release(input int sel, input string tag);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, get_valid(sel), 0);
        check({tag, "_ready_back"}, get_ready(sel), 1);
    endtask

    typedef struct {
        int          sel;
        logic [31:0] data;
        logic [1:0]  mode;
        int          exp_bit;
        int          exp_hit;
        int          exp_idx;
        int          exp_lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int b, h, idx, lat, bad, eb, eh, ei, sel, w, n, stall_b, stall_h, stall_i, seen;
        logic [31:0] d;
        logic [1:0]  m;

        vecs[0] = '{0, 32'h0100, 2'b00, 1, 1, 8,  4};
        vecs[1] = '{0, 32'hFFFF, 2'b01, 1, 1, 0,  4};
        vecs[2] = '{0, 32'hFFFE, 2'b01, 0, 1, 1,  4};
        vecs[3] = '{0, 32'h8007, 2'b10, 0, 1, 0,  4};
        vecs[4] = '{0, 32'h0007, 2'b10, 1, 1, 0,  4};
        vecs[5] = '{0, 32'h0000, 2'b11, 1, 0, 0,  4};
        vecs[6] = '{0, 32'h8000, 2'b11, 0, 1, 15, 4};
        vecs[7] = '{0, 32'h0000, 2'b01, 0, 0, 0,  4};
        vecs[8] = '{1, 32'h0000, 2'b00, 0, 0, 0,  1};
        vecs[9] = '{1, 32'h0020, 2'b00, 1, 1, 5,  1};

        for (int s = 0; s < 3; s++) begin
            drive(s, 1'b0, 32'h0, 2'b00);
            set_out_ready(s, 1'b1);
        end
        rst_n = 1'b0;
        #23;
        check("rst_in_ready",  get_ready(0), 1);
        check("rst_out_valid", get_valid(0), 0);
        check("rst_out_bit",   get_bit(0),   0);
        check("rst_out_hit",   get_hit(0),   0);
        check("rst_out_idx",   get_idx(0),   0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------------------------------------------- directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].data, vecs[i].mode, b, h, idx, lat, bad);
            check($sformatf("vec%0d_bit", i), b,   vecs[i].exp_bit);
            check($sformatf("vec%0d_hit", i), h,   vecs[i].exp_hit);
            check($sformatf("vec%0d_idx", i), idx, vecs[i].exp_idx);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_ready_protocol", i), bad, 0);
            check_release(vecs[i].sel, $sformatf("vec%0d", i));
        end

        // ---------------------------------------------------- backpressure
        set_out_ready(0, 1'b0);
        run_op(0, 32'h0340, 2'b00, b, h, idx, lat, bad);
        check("bp_bit", b, 1);
        check("bp_hit", h, 1);
        check("bp_idx", idx, 6);
        stall_b = b; stall_h = h; stall_i = idx;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) drive(0, 1'b1, 32'hFFFF, 2'b01);
            if (c == 3) drive(0, 1'b0, 32'h0, 2'b00);
            check($sformatf("bp_hold%0d_valid", c), get_valid(0), 1);
            check($sformatf("bp_hold%0d_ready", c), get_ready(0), 0);
            check($sformatf("bp_hold%0d_bit", c),   get_bit(0),   stall_b);
            check($sformatf("bp_hold%0d_hit", c),   get_hit(0),   stall_h);
            check($sformatf("bp_hold%0d_idx", c),   get_idx(0),   stall_i);
        end
        set_out_ready(0, 1'b1);
        check_release(0, "bp");
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (get_valid(0) != 0 || get_ready(0) != 1) seen = 1;
        end
        check("bp_stall_word_ignored", seen, 0);

        // ---------------------------------------------------- reset mid-RUN
        @(negedge clk);
        drive(0, 1'b1, 32'h00F0, 2'b00);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 32'h0, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_mid_pre_hit", get_hit(0), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", get_valid(0), 0);
        check("rst_mid_bit",   get_bit(0),   0);
        check("rst_mid_hit",   get_hit(0),   0);
        check("rst_mid_idx",   get_idx(0),   0);
        check("rst_mid_ready", get_ready(0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (get_valid(0) != 0 || get_ready(0) != 1) seen = 1;
        end
        check("rst_mid_discarded", seen, 0);
        run_op(0, 32'h00F0, 2'b00, b, h, idx, lat, bad);
        check("rst_fresh_bit", b, 1);
        check("rst_fresh_hit", h, 1);
        check("rst_fresh_idx", idx, 4);
        check("rst_fresh_lat", lat, 4);
        check_release(0, "rst_fresh");

        // ---------------------------------------------------- random sweep
        for (int t = 0; t < 60; t++) begin
            sel = (t % 3 == 0) ? 0 : 2;
            w   = (sel == 0) ? 16 : 32;
            n   = (sel == 0) ? 4 : 4;
            case ($urandom_range(0, 3))
                0:       d = 32'h0;
                1:       d = 32'h1 << $urandom_range(0, w - 1);
                2:       d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
            m = 2'($urandom_range(0, 3));
            ref_reduce(d, w, m, eb, eh, ei);
            run_op(sel, d, m, b, h, idx, lat, bad);
            check($sformatf("rnd%0d_bit", t), b,   eb);
            check($sformatf("rnd%0d_hit", t), h,   eh);
            check($sformatf("rnd%0d_idx", t), idx, ei);
            check($sformatf("rnd%0d_lat", t), lat, n);
            check($sformatf("rnd%0d_ready_protocol", t), bad, 0);
            check_release(sel, $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reduce_seq.md
# reduce_seq

Parametrised, multi-cycle bit-reduction unit and the successor to the fixed 8-input OR reduction. It accepts a WIDTH-bit word over a valid/ready handshake and reduces it CHUNK bits per cycle under a selectable mode (OR, AND, XOR, NOR). It also reports the index of the lowest set bit. It sits between register/ALU datapaths and control logic that needs flag-style summaries of wide buses without a long combinational reduction tree.

## Interface
- WIDTH, 16, input word width; must be a multiple of CHUNK, ≥ 2
- CHUNK, 4, bits reduced per cycle; N = WIDTH/CHUNK reduction cycles
- IW, $clog2(WIDTH), width of index output (derived, not overridden)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept; high only in IDLE
- in_data  input  WIDTH  word to reduce
- mode  input  2  00 OR, 01 AND, 10 XOR, 11 NOR; sampled with in_data
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_bit  output  1  reduction result
- out_hit  output  1  at least one bit of in_data was 1
- out_idx  output  IW  index of lowest set bit of in_data; 0 when out_hit=0

## Operation
- States: IDLE, RUN, DONE. Reset (rst_n low, asynchronous) forces IDLE, clears data/mode registers, chunk counter, accumulator, out_bit, out_hit and out_idx to 0, and clears out_valid to 0.
- in_ready = (state==IDLE), combinational from state. No transfer is taken while rst_n is low.
- IDLE: on in_valid && in_ready at a rising edge, latch in_data and mode, set counter=0, and initialise the accumulator. The accumulator starts at 1 for AND and at 0 for OR/XOR/NOR. Clear hit/idx, then go to RUN.
- RUN: each cycle, fold chunk[counter] (bits counter*CHUNK+CHUNK-1 .. counter*CHUNK) into the accumulator.
  - OR/NOR use |, AND uses &, XOR uses ^.
  - If hit is 0 and the chunk is nonzero, set hit=1 and idx = counter*CHUNK + position of the lowest set bit in the chunk. Later chunks never change idx.
  - When counter == N-1, go to DONE; otherwise counter+1.
- DONE: out_valid=1. out_bit = accumulator, inverted for NOR. out_bit, out_hit and out_idx are held stable until out_valid && out_ready. On that edge, go to IDLE and drop out_valid.
- mode and in_data changes outside the accept edge have no effect.
- Counter width is $clog2(N), minimum 1. Index arithmetic is performed in IW bits and does not wrap for legal parameters.
- No overlap: a new request cannot be accepted in the same cycle a result is consumed. in_ready rises the cycle after the output handshake.
- Reset mid-RUN or mid-DONE discards the operation; no out_valid is produced for it.

## Timing
- Accept at edge t. RUN occupies edges t+1 .. t+N, and out_valid is high after edge t+N.
- Latency from the accept edge to out_valid is N cycles. Minimum issue interval is N+2 cycles with out_ready held high (accept, N RUN edges, one DONE/handshake edge, back in IDLE).
- With N=1 (CHUNK=WIDTH), out_valid is high one cycle after accept.
- out_* are registered outputs; no combinational path from in_* or out_ready to any output except in_ready (from state only).

## Test plan
- WIDTH=16, CHUNK=4, OR, in_data=16'h0100 -> out_valid 4 cycles after accept; out_bit=1, out_hit=1, out_idx=8; in_ready low from accept until one cycle after the output handshake.
- AND with 16'hFFFF -> out_bit=1, out_idx=0. AND with 16'hFFFE -> out_bit=0, out_hit=1, out_idx=1. XOR with 16'h8007 -> out_bit=0, out_idx=0. XOR with 16'h0007 -> out_bit=1.
- NOR with 16'h0000 -> out_bit=1, out_hit=0, out_idx=0. NOR with 16'h8000 -> out_bit=0, out_idx=15.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_bit/out_hit/out_idx stable and in_ready=0. Pulse in_valid with another word during the stall -> that word is not accepted. Raise out_ready -> out_valid drops next edge, and in_ready=1 after it.
- Reset: assert rst_n=0 asynchronously mid-RUN (counter=2) -> immediately out_valid=0 and outputs 0; after release, state is IDLE with in_ready=1. A fresh request then completes with correct values.
- Parameter sweep: WIDTH=8, CHUNK=8 with OR on 8'h00 and 8'h20 -> latency 1, out_bit=0/1, out_idx=0/5. WIDTH=32, CHUNK=8 with random vectors and modes checked against a reference reduction and a lowest-set-bit model.
